// File: rtl/spi_cmd_decoder.sv
// SPI-slave register-access decoder: samples SPI pins in the system clock domain,
// decodes a two-byte opcode/data frame and issues single-cycle fetch/load strobes.
module spi_cmd_decoder #(
  parameter int SYNC_STAGES = 2  // legal range 2..3
) (
  input  logic       i_sys_clk,
  input  logic       i_rst_b,
  input  logic       i_spi_sck,
  input  logic       i_spi_mosi,
  input  logic       i_spi_cs_n,
  output logic       o_spi_miso,
  output logic       o_spi_miso_oe,
  output logic [4:0] o_ioc,
  output logic [7:0] o_data_out,
  input  logic [7:0] i_data_in_sys,
  input  logic [7:0] i_data_in_io,
  input  logic [7:0] i_data_in_smi,
  output logic       o_cs_sys,
  output logic       o_cs_io,
  output logic       o_cs_smi,
  output logic       o_fetch_cmd,
  output logic       o_load_cmd
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_OPCODE    = 3'd1,
    S_FETCH     = 3'd2,
    S_WAIT_DATA = 3'd3,
    S_DATA      = 3'd4,
    S_COMMIT    = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_csn_sync;
  logic                   r_sck_prev;
  logic                   r_csn_prev;

  logic [7:0] r_rx_sr;
  logic [7:0] r_tx_sr;
  logic [4:0] r_bit_cnt;
  logic [7:0] r_opcode;
  logic [4:0] r_ioc;
  logic [7:0] r_data_out;

  logic       w_sck;
  logic       w_mosi;
  logic       w_csn;
  logic       w_sck_rise;
  logic       w_sck_fall;
  logic       w_cs_fall;
  logic [7:0] w_rx_next;
  logic       w_in_frame;
  logic       w_opcode_done;
  logic       w_data_done;
  logic       w_commit;
  logic       w_tx_shift;
  logic [7:0] w_rd_data;
  logic       w_strobe;

  assign w_sck      = r_sck_sync[SYNC_STAGES-1];
  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign w_csn      = r_csn_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck & ~r_sck_prev;
  assign w_sck_fall = ~w_sck & r_sck_prev;
  assign w_cs_fall  = ~w_csn & r_csn_prev;
  assign w_rx_next  = {r_rx_sr[6:0], w_mosi};

  // SCK rises keep counting through FETCH/WAIT_DATA so a fast host cannot desync the frame.
  assign w_in_frame    = (r_state == S_OPCODE) || (r_state == S_FETCH) ||
                         (r_state == S_WAIT_DATA) || (r_state == S_DATA);
  assign w_opcode_done = (r_state == S_OPCODE) && w_sck_rise && (r_bit_cnt == 5'd7);
  assign w_data_done   = (r_state == S_DATA) && w_sck_rise && (r_bit_cnt == 5'd15);
  assign w_commit      = r_opcode[7] && (r_opcode[6:5] != 2'b11);
  assign w_tx_shift    = (r_state == S_DATA) && w_sck_fall &&
                         (r_bit_cnt >= 5'd9) && (r_bit_cnt <= 5'd15);

  always_comb begin
    w_rd_data = 8'h00;
    case (r_opcode[6:5])
      2'b00:   w_rd_data = i_data_in_sys;
      2'b01:   w_rd_data = i_data_in_io;
      2'b10:   w_rd_data = i_data_in_smi;
      default: w_rd_data = 8'h00;
    endcase
  end

  // Pin synchronisers reset to the idle bus level: SCK low, CSn high.
  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_b) begin
      r_sck_sync  <= '0;
      r_mosi_sync <= '0;
      r_csn_sync  <= '1;
      r_sck_prev  <= 1'b0;
      r_csn_prev  <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], i_spi_sck};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
      r_csn_sync  <= {r_csn_sync[SYNC_STAGES-2:0], i_spi_cs_n};
      r_sck_prev  <= w_sck;
      r_csn_prev  <= w_csn;
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_b) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_csn) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cs_fall) w_state_nxt = S_OPCODE;
        end
        S_OPCODE: begin
          if (w_opcode_done) begin
            if (!w_rx_next[7] && (w_rx_next[6:5] != 2'b11)) w_state_nxt = S_FETCH;
            else                                             w_state_nxt = S_DATA;
          end
        end
        S_FETCH:     w_state_nxt = S_WAIT_DATA;
        S_WAIT_DATA: w_state_nxt = S_DATA;
        S_DATA: begin
          if (w_data_done) w_state_nxt = w_commit ? S_COMMIT : S_DONE;
        end
        S_COMMIT:    w_state_nxt = S_DONE;
        S_DONE:      w_state_nxt = S_DONE;
        default:     w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign w_strobe    = (r_state == S_FETCH) || (r_state == S_COMMIT);
  always_comb begin
    o_fetch_cmd = (r_state == S_FETCH);
    o_load_cmd  = (r_state == S_COMMIT);
    o_cs_sys    = w_strobe && (r_opcode[6:5] == 2'b00);
    o_cs_io     = w_strobe && (r_opcode[6:5] == 2'b01);
    o_cs_smi    = w_strobe && (r_opcode[6:5] == 2'b10);
  end

  // r_ioc/r_data_out load on the edge entering FETCH/COMMIT so they are valid with the strobe.
  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_b) begin
      r_rx_sr    <= 8'h00;
      r_tx_sr    <= 8'h00;
      r_bit_cnt  <= 5'd0;
      r_opcode   <= 8'h00;
      r_ioc      <= 5'd0;
      r_data_out <= 8'h00;
    end else if (w_csn) begin
      r_rx_sr   <= 8'h00;
      r_tx_sr   <= 8'h00;
      r_bit_cnt <= 5'd0;
    end else begin
      if ((r_state == S_IDLE) && w_cs_fall) begin
        r_bit_cnt <= 5'd0;
        r_tx_sr   <= 8'h00;
      end
      if (w_in_frame && w_sck_rise) begin
        r_rx_sr <= w_rx_next;
        if (r_bit_cnt != 5'd16) r_bit_cnt <= r_bit_cnt + 5'd1;
      end
      if (w_opcode_done) begin
        r_opcode <= w_rx_next;
        if (!w_rx_next[7] && (w_rx_next[6:5] != 2'b11)) r_ioc <= w_rx_next[4:0];
      end
      if (r_state == S_WAIT_DATA) r_tx_sr <= w_rd_data;
      if (w_tx_shift) r_tx_sr <= {r_tx_sr[6:0], 1'b0};
      if (w_data_done && w_commit) begin
        r_ioc      <= r_opcode[4:0];
        r_data_out <= w_rx_next;
      end
    end
  end

  assign o_ioc         = r_ioc;
  assign o_data_out    = r_data_out;
  assign o_spi_miso    = r_tx_sr[7];
  assign o_spi_miso_oe = ~w_csn;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed bench for spi_cmd_decoder: drives SPI frames as a mode-0 master and
// checks strobes, held outputs and MISO against a frame-level model.
module tb_spi_cmd_decoder;
  localparam int SYNC = 2;
  localparam int EW   = 18;  // {cs[2:0], fetch, load, ioc[4:0], data[7:0]}

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_b;
  logic       sck, mosi, cs_n;
  logic [7:0] data_in_sys = 8'hEE;
  logic [7:0] data_in_io  = 8'hEE;
  logic [7:0] data_in_smi = 8'hEE;
  logic       miso, miso_oe;
  logic [4:0] ioc;
  logic [7:0] data_out;
  logic       cs_sys, cs_io, cs_smi, fetch_cmd, load_cmd;

  spi_cmd_decoder #(.SYNC_STAGES(SYNC)) dut (
    .i_sys_clk(clk), .i_rst_b(rst_b),
    .i_spi_sck(sck), .i_spi_mosi(mosi), .i_spi_cs_n(cs_n),
    .o_spi_miso(miso), .o_spi_miso_oe(miso_oe),
    .o_ioc(ioc), .o_data_out(data_out),
    .i_data_in_sys(data_in_sys), .i_data_in_io(data_in_io), .i_data_in_smi(data_in_smi),
    .o_cs_sys(cs_sys), .o_cs_io(cs_io), .o_cs_smi(cs_smi),
    .o_fetch_cmd(fetch_cmd), .o_load_cmd(load_cmd)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  logic [7:0]    mod_val [0:2];
  int            rise_cyc [0:23];
  logic [4:0]    last_ioc  = 5'd0;
  logic [7:0]    last_data = 8'h00;
  logic [2:0]    last_cs   = 3'b000;
  int            fetch_cnt = 0;
  int            load_cnt  = 0;
  logic [EW-1:0] mon_e;
  int            lat;
  logic [SYNC-1:0] cs_hist;

  function automatic logic [2:0] sel_hot(input logic [1:0] sel);
    case (sel)
      2'b00:   return 3'b100;
      2'b01:   return 3'b010;
      2'b10:   return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  // MISO enable follows CSn delayed by the synchroniser depth.
  always @(posedge clk) begin
    if (!rst_b) cs_hist <= '1;
    else        cs_hist <= {cs_hist[SYNC-2:0], cs_n};
  end

  // compare process + register-file model answering fetches
  always @(negedge clk) begin
    if (cs_n) begin
      data_in_sys = 8'hEE;
      data_in_io  = 8'hEE;
      data_in_smi = 8'hEE;
    end
    if (!rst_b) begin
      last_ioc  = 5'd0;
      last_data = 8'h00;
    end else begin
      chk("miso_oe", miso_oe, !cs_hist[SYNC-1]);
      if ({cs_sys, cs_io, cs_smi, fetch_cmd, load_cmd} != 5'b0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got cs=%b fetch=%b load=%b expected none",
                   {cs_sys, cs_io, cs_smi}, fetch_cmd, load_cmd);
        end else begin
          mon_e = exp_q.pop_front();
          chk("strobe_kind", {cs_sys, cs_io, cs_smi, fetch_cmd, load_cmd}, mon_e[17:13]);
          last_ioc = mon_e[12:8];
          if (mon_e[13]) last_data = mon_e[7:0];
          lat = cyc - (mon_e[13] ? rise_cyc[15] : rise_cyc[7]);
          checks++;
          if (lat < SYNC + 1 || lat > SYNC + 2) begin
            errors++;
            $display("FAIL strobe_latency: got %0d cycles expected %0d..%0d", lat, SYNC + 1, SYNC + 2);
          end
          last_cs = {cs_sys, cs_io, cs_smi};
          if (fetch_cmd) begin
            fetch_cnt++;
            if (cs_sys) data_in_sys = mod_val[0];
            if (cs_io)  data_in_io  = mod_val[1];
            if (cs_smi) data_in_smi = mod_val[2];
          end
          if (load_cmd) load_cnt++;
        end
      end
      chk("ioc_hold", ioc, last_ioc);
      chk("data_out_hold", data_out, last_data);
    end
  end

  // driver: one SPI mode-0 frame of nbits, optionally ended by a reset instead of CSn rise
  task automatic frame(input logic [7:0] op, input logic [7:0] b1, input logic [7:0] b2,
                       input int nbits, input bit rst_abort, output logic [23:0] rx);
    logic [23:0] tx;
    logic [23:0] exp_rx;
    logic [7:0]  rd_val;
    logic        valid;
    tx     = {op, b1, b2};
    rx     = 24'h0;
    exp_rx = 24'h0;
    valid  = (op[6:5] != 2'b11);
    rd_val = (!op[7] && valid) ? mod_val[op[6:5]] : 8'h00;
    if (nbits >= 8 && !op[7] && valid)
      exp_q.push_back({sel_hot(op[6:5]), 1'b1, 1'b0, op[4:0], 8'h00});
    if (nbits >= 16 && op[7] && valid && !rst_abort)
      exp_q.push_back({sel_hot(op[6:5]), 1'b0, 1'b1, op[4:0], b1});
    for (int i = 0; i < nbits; i++) begin
      if (i >= 8 && i < 16) exp_rx[23-i] = rd_val[15-i];
      else if (i >= 16)     exp_rx[23-i] = rd_val[0];
    end
    @(negedge clk) cs_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[23-i];
      repeat (4) @(negedge clk);
      rx[23-i] = miso;
      sck = 1'b1;
      rise_cyc[i] = cyc;
      repeat (4) @(negedge clk);
      sck = 1'b0;
    end
    if (rst_abort) begin
      rst_b = 1'b0;
      cs_n  = 1'b1;
      mosi  = 1'b0;
      @(negedge clk);
      chk("rst_mid_outputs", {cs_sys, cs_io, cs_smi, fetch_cmd, load_cmd, miso, miso_oe}, 7'b0);
      chk("rst_mid_ioc", ioc, 5'h00);
      chk("rst_mid_data_out", data_out, 8'h00);
      rst_b = 1'b1;
      repeat (SYNC + 4) @(negedge clk);
    end else begin
      repeat (6) @(negedge clk);
      cs_n = 1'b1;
      mosi = 1'b0;
      repeat (SYNC + 4) @(negedge clk);
    end
    chk("miso_stream", rx, exp_rx);
  endtask

  int          f0, l0;
  logic [23:0] rx;

  initial begin
    rst_b = 1'b0;
    sck   = 1'b0;
    mosi  = 1'b0;
    cs_n  = 1'b1;
    mod_val[0] = 8'h00;
    mod_val[1] = 8'h00;
    mod_val[2] = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_strobes", {cs_sys, cs_io, cs_smi, fetch_cmd, load_cmd}, 5'b0);
    chk("reset_miso", {miso, miso_oe}, 2'b00);
    chk("reset_ioc_data", {ioc, data_out}, 13'h0);
    rst_b = 1'b1;
    repeat (4) @(negedge clk);

    // write sys soft reset
    l0 = load_cnt;
    frame(8'h84, 8'hA5, 8'h00, 16, 1'b0, rx);
    chk("wsys_load_count", load_cnt - l0, 1);
    chk("wsys_ioc", last_ioc, 5'h04);
    chk("wsys_data", last_data, 8'hA5);
    chk("wsys_cs", last_cs, 3'b100);

    // read sys version
    mod_val[0] = 8'h01;
    f0 = fetch_cnt;
    frame(8'h01, 8'h00, 8'h00, 16, 1'b0, rx);
    chk("rsys_fetch_count", fetch_cnt - f0, 1);
    chk("rsys_ioc", last_ioc, 5'h01);
    chk("rsys_miso_byte1", rx[15:8], 8'h01);
    chk("rsys_miso_byte0", rx[23:16], 8'h00);

    // read io
    mod_val[1] = 8'h5C;
    frame(8'h23, 8'h00, 8'h00, 16, 1'b0, rx);
    chk("rio_miso", rx[15:8], 8'h5C);
    chk("rio_cs", last_cs, 3'b010);

    // reserved select read: no strobe, MISO zero
    f0 = fetch_cnt;
    l0 = load_cnt;
    frame(8'h63, 8'h00, 8'h00, 16, 1'b0, rx);
    chk("rres_strobes", (fetch_cnt - f0) + (load_cnt - l0), 0);
    chk("rres_miso", rx[15:8], 8'h00);

    // write smi aborted after 12 bits, then a clean write io
    l0 = load_cnt;
    frame(8'hC2, 8'h99, 8'h00, 12, 1'b0, rx);
    chk("abort_no_load", load_cnt - l0, 0);
    frame(8'hBF, 8'h5A, 8'h00, 16, 1'b0, rx);
    chk("post_abort_data", last_data, 8'h5A);
    chk("post_abort_ioc", last_ioc, 5'h1F);

    // overlong write to smi (opcode 0xC1): extra SCK cycles ignored
    l0 = load_cnt;
    frame(8'hC1, 8'h3C, 8'hFF, 24, 1'b0, rx);
    chk("long_load_count", load_cnt - l0, 1);
    chk("long_data", last_data, 8'h3C);
    chk("long_cs", last_cs, 3'b001);

    // overlong read smi: MISO holds last bit after the frame
    mod_val[2] = 8'hC3;
    frame(8'h5E, 8'h00, 8'h00, 24, 1'b0, rx);
    chk("rsmi_miso", rx[15:0], 16'hC3FF);

    // reset during DATA of a read, then a normal write
    mod_val[0] = 8'h77;
    frame(8'h02, 8'h00, 8'h00, 11, 1'b1, rx);
    frame(8'h85, 8'h3E, 8'h00, 16, 1'b0, rx);
    chk("post_rst_data", last_data, 8'h3E);
    chk("post_rst_ioc", last_ioc, 5'h05);

    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
